// File: rtl/intr_ctrl_if.sv
//==============================================================================
// intr_ctrl_if : source/enable inputs, EXU handshake and status outputs.
// Revision 1.0
//==============================================================================
`default_nettype none

interface intr_ctrl_if #(
    parameter int NUM_SRC = 4
);
    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] intr_src;
    logic [NUM_SRC-1:0] intr_en;
    logic               ifu_exu_vld_d;
    logic               exu_intr_done;
    logic               intr_pulse;
    logic [ID_W-1:0]    intr_id;
    logic               intr_busy;
    logic [NUM_SRC-1:0] intr_pending;

    modport master (
        output intr_src, intr_en, ifu_exu_vld_d, exu_intr_done,
        input  intr_pulse, intr_id, intr_busy, intr_pending
    );

    modport slave (
        input  intr_src, intr_en, ifu_exu_vld_d, exu_intr_done,
        output intr_pulse, intr_id, intr_busy, intr_pending
    );
endinterface

`default_nettype wire

// File: rtl/intr_ctrl.sv
//==============================================================================
// intr_ctrl : edge-triggered interrupt controller, one delivery in flight.
// Macro INTR_CTRL_RR_EN selects round-robin arbitration (default fixed prio).
// Revision 1.0
//==============================================================================
`default_nettype none

module intr_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    localparam int ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input wire         clk,
    input wire         rst,
    intr_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_BUSY = 2'd3;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] pend_d;
    logic [NUM_SRC-1:0] clr_w;
    logic [NUM_SRC-1:0] elig_w;
    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    id_d;
    logic [ID_W-1:0]    win_id_w;
    logic               win_vld_w;
    logic               pulse_w;
    logic               busy_w;

    // Synchronizer chain followed by a registered rising-edge detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
            edge_q <= '0;
        end else begin
            sync_q[0] <= bus.intr_src;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign elig_w = pend_q & bus.intr_en;
    // New edge is OR-ed after the delivery clear so it survives a same-cycle clear.
    assign pend_d = (pend_q & ~clr_w) | edge_q;

`ifdef INTR_CTRL_RR_EN
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    always_comb begin
        int idx;
        idx       = 0;
        win_vld_w = 1'b0;
        win_id_w  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!win_vld_w && elig_w[idx[ID_W-1:0]]) begin
                win_vld_w = 1'b1;
                win_id_w  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_SEND) begin
            ptr_d = (id_q == ID_W'(NUM_SRC - 1)) ? '0 : id_q + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        win_vld_w = 1'b0;
        win_id_w  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig_w[i]) begin
                win_vld_w = 1'b1;
                win_id_w  = ID_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        clr_w   = '0;
        case (state_q)
            S_IDLE: begin
                if (|elig_w) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (!win_vld_w) begin
                    state_d = S_IDLE;
                end else if (bus.ifu_exu_vld_d) begin
                    id_d    = win_id_w;
                    clr_w   = NUM_SRC'(1) << win_id_w;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (bus.exu_intr_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pulse_w = 1'b0;
        busy_w  = 1'b0;
        case (state_q)
            S_SEND:  pulse_w = 1'b1;
            S_BUSY:  busy_w  = 1'b1;
            default: begin
                pulse_w = 1'b0;
                busy_w  = 1'b0;
            end
        endcase
    end

    assign bus.intr_pulse   = pulse_w;
    assign bus.intr_busy    = busy_w;
    assign bus.intr_id      = id_q;
    assign bus.intr_pending = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_intr_ctrl.sv
//==============================================================================
// tb_intr_ctrl : directed scenarios plus randomized run against a
// transaction-level reference model.
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_intr_ctrl;
    localparam int N   = 4;
    localparam int S   = 2;
    localparam int IDW = 2;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_SEND = 2;
    localparam int P_BUSY = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    intr_ctrl_if #(.NUM_SRC(N)) bus ();

    intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: history of sampled source levels, pending set, service phase.
    logic [N-1:0] m_hist [$];
    logic [N-1:0] m_edge;
    logic [N-1:0] m_pend;
    int           m_phase;
    int           m_id;
    int           m_ptr;

    function automatic int pick(input logic [N-1:0] e, input int start);
        for (int k = 0; k < N; k++) begin
            if (e[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        repeat (S + 2) m_hist.push_back('0);
        m_edge  = '0;
        m_pend  = '0;
        m_phase = P_IDLE;
        m_id    = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] elig;
        logic [N-1:0] next_pend;
        int w;
        elig      = m_pend & bus.intr_en;
        next_pend = m_pend;
        case (m_phase)
            P_IDLE: if (elig != 0) m_phase = P_ARM;
            P_ARM: begin
                if (elig == 0) m_phase = P_IDLE;
                else if (bus.ifu_exu_vld_d) begin
`ifdef INTR_CTRL_RR_EN
                    w = pick(elig, m_ptr);
`else
                    w = pick(elig, 0);
`endif
                    m_id         = w;
                    next_pend[w] = 1'b0;
                    m_phase      = P_SEND;
                end
            end
            P_SEND: begin
                m_ptr   = (m_id + 1) % N;
                m_phase = P_BUSY;
            end
            default: if (bus.exu_intr_done) m_phase = P_IDLE;
        endcase
        m_pend = next_pend | m_edge;
        m_hist.push_back(bus.intr_src);
        void'(m_hist.pop_front());
        m_edge = m_hist[1] & ~m_hist[0];
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) cyc();
        checks++;
        if (bus.intr_pulse !== 1'b0 || bus.intr_busy !== 1'b0 || bus.intr_id !== 0 || bus.intr_pending !== 0) begin
            errors++;
            $display("FAIL reset_outputs: pulse=%b busy=%b id=%0d pend=%b, required all zero",
                     bus.intr_pulse, bus.intr_busy, bus.intr_id, bus.intr_pending);
        end
        rst = 1'b0;
        repeat (2) cyc();
        checks++;
        if (bus.intr_pulse !== 1'b0 || bus.intr_busy !== 1'b0 || bus.intr_pending !== 0) begin
            errors++;
            $display("FAIL reset_release_idle: pulse=%b busy=%b pend=%b, required all zero",
                     bus.intr_pulse, bus.intr_busy, bus.intr_pending);
        end
    endtask

    task automatic test_single();
        int first;
        int extra;
        first = 0;
        extra = 0;
        bus.intr_en       = '1;
        bus.ifu_exu_vld_d = 1'b1;
        bus.intr_src      = 4'b0100;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (bus.intr_pulse === 1'b1) begin
                first = c;
                break;
            end
        end
        checks++;
        if (first !== S + 4) begin
            errors++;
            $display("FAIL single_latency: pulse after %0d cycles, required %0d", first, S + 4);
        end
        checks++;
        if (bus.intr_id !== 2) begin
            errors++;
            $display("FAIL single_id: id=%0d, required 2", bus.intr_id);
        end
        checks++;
        if (bus.intr_pending[2] !== 1'b0) begin
            errors++;
            $display("FAIL single_pending_clear: pending[2]=%b, required 0", bus.intr_pending[2]);
        end
        cyc();
        checks++;
        if (bus.intr_pulse !== 1'b0 || bus.intr_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: pulse=%b busy=%b, required pulse 0 busy 1", bus.intr_pulse, bus.intr_busy);
        end
        repeat (4) begin
            cyc();
            if (bus.intr_pulse === 1'b1 || bus.intr_busy !== 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL single_hold_busy: %0d bad cycles, required 0", extra);
        end
        bus.exu_intr_done = 1'b1;
        cyc();
        bus.exu_intr_done = 1'b0;
        checks++;
        if (bus.intr_busy !== 1'b0 || bus.intr_id !== 2) begin
            errors++;
            $display("FAIL single_done: busy=%b id=%0d, required busy 0 id 2", bus.intr_busy, bus.intr_id);
        end
        bus.intr_src = '0;
        repeat (4) cyc();
    endtask

    task automatic test_priority();
        int ids [$];
        int exp0;
        int exp1;
`ifdef INTR_CTRL_RR_EN
        exp0 = 3;
        exp1 = 1;
`else
        exp0 = 1;
        exp1 = 3;
`endif
        bus.intr_src      = 4'b1010;
        bus.ifu_exu_vld_d = 1'b1;
        for (int c = 0; c < 60; c++) begin
            cyc();
            if (bus.intr_pulse === 1'b1) ids.push_back(int'(bus.intr_id));
            bus.exu_intr_done = (bus.intr_busy === 1'b1);
        end
        bus.exu_intr_done = 1'b0;
        bus.intr_src      = '0;
        checks++;
        if (ids.size() != 2) begin
            errors++;
            $display("FAIL priority_count: %0d pulses, required 2", ids.size());
        end
        checks++;
        if (ids.size() < 2 || ids[0] != exp0 || ids[1] != exp1) begin
            errors++;
            $display("FAIL priority_order: ids=%p, required %0d then %0d", ids, exp0, exp1);
        end
    endtask

    task automatic test_rr();
        int ids [$];
        int rer [N];
        int hold;
        int k;
        rer  = '{default: 0};
        hold = 0;
        bus.intr_en       = '1;
        bus.ifu_exu_vld_d = 1'b1;
        bus.intr_src      = 4'b0011;
        for (int c = 0; c < 400 && ids.size() < 4; c++) begin
            cyc();
            if (bus.intr_pulse === 1'b1) begin
                k = int'(bus.intr_id);
                ids.push_back(k);
                bus.intr_src[k] = 1'b0;
                rer[k] = 3;
                hold   = 12;
            end
            for (int j = 0; j < N; j++) begin
                if (rer[j] > 0) begin
                    rer[j]--;
                    if (rer[j] == 0) bus.intr_src[j] = 1'b1;
                end
            end
            if (bus.intr_busy === 1'b1 && hold > 0) hold--;
            bus.exu_intr_done = (bus.intr_busy === 1'b1) && (hold == 0);
        end
        bus.intr_src      = '0;
        bus.exu_intr_done = 1'b0;
        checks++;
`ifdef INTR_CTRL_RR_EN
        if (ids.size() != 4 || ids[0] != 0 || ids[1] != 1 || ids[2] != 0 || ids[3] != 1) begin
            errors++;
            $display("FAIL rr_sequence: ids=%p, required 0 1 0 1", ids);
        end
`else
        if (ids.size() != 4 || ids[0] != 0 || ids[1] != 0 || ids[2] != 0 || ids[3] != 0) begin
            errors++;
            $display("FAIL fixed_sequence: ids=%p, required 0 0 0 0", ids);
        end
`endif
    endtask

    task automatic drain();
        bus.intr_src      = '0;
        bus.intr_en       = '1;
        bus.ifu_exu_vld_d = 1'b1;
        for (int c = 0; c < 80; c++) begin
            cyc();
            bus.exu_intr_done = (bus.intr_busy === 1'b1);
        end
        bus.exu_intr_done = 1'b0;
    endtask

    task automatic test_mask();
        int pulses;
        int got;
        pulses = 0;
        got    = 0;
        bus.intr_en       = '0;
        bus.ifu_exu_vld_d = 1'b0;
        bus.intr_src      = 4'b0001;
        repeat (12) begin
            cyc();
            if (bus.intr_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL mask_no_pulse: %0d pulses, required 0", pulses);
        end
        checks++;
        if (bus.intr_pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL mask_pending: pending[0]=%b, required 1", bus.intr_pending[0]);
        end
        bus.intr_en       = 4'b0001;
        bus.ifu_exu_vld_d = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (bus.intr_pulse === 1'b1) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (got != 1 || bus.intr_id !== 0) begin
            errors++;
            $display("FAIL mask_reenable: pulse_seen=%0d id=%0d, required pulse with id 0", got, bus.intr_id);
        end
        cyc();
        bus.exu_intr_done = 1'b1;
        cyc();
        bus.exu_intr_done = 1'b0;
        bus.intr_src      = '0;
    endtask

    task automatic test_busy_rerise_reset();
        int got;
        int bad;
        got = 0;
        bad = 0;
        bus.intr_en       = '1;
        bus.ifu_exu_vld_d = 1'b1;
        bus.intr_src      = 4'b0010;
        for (int c = 0; c < 20 && got == 0; c++) begin
            cyc();
            if (bus.intr_pulse === 1'b1) got = 1;
        end
        checks++;
        if (got != 1 || bus.intr_id !== 1) begin
            errors++;
            $display("FAIL rerise_first: pulse_seen=%0d id=%0d, required pulse with id 1", got, bus.intr_id);
        end
        bus.intr_src = '0;
        repeat (3) cyc();
        bus.intr_src = 4'b0010;
        repeat (6) cyc();
        checks++;
        if (bus.intr_busy !== 1'b1 || bus.intr_pending[1] !== 1'b1) begin
            errors++;
            $display("FAIL rerise_recorded: busy=%b pending[1]=%b, required 1 and 1", bus.intr_busy, bus.intr_pending[1]);
        end
        bus.exu_intr_done = 1'b1;
        cyc();
        bus.exu_intr_done = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            cyc();
            if (bus.intr_pulse === 1'b1) got = 1;
        end
        checks++;
        if (got != 1 || bus.intr_id !== 1) begin
            errors++;
            $display("FAIL rerise_second: pulse_seen=%0d id=%0d, required pulse with id 1", got, bus.intr_id);
        end
        cyc();
        bus.exu_intr_done = 1'b1;
        cyc();
        bus.exu_intr_done = 1'b0;
        // Park the FSM in ARM (pending, enabled, no decode-valid), then reset.
        bus.ifu_exu_vld_d = 1'b0;
        bus.intr_src      = '0;
        repeat (4) cyc();
        bus.intr_src = 4'b0010;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            cyc();
            if (bus.intr_pending[1] === 1'b1) got = 1;
        end
        bus.intr_src = '0;
        repeat (4) cyc();
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (got != 1 || bus.intr_pulse !== 1'b0 || bus.intr_busy !== 1'b0 || bus.intr_id !== 0 || bus.intr_pending !== 0) begin
            errors++;
            $display("FAIL arm_reset: armed=%0d pulse=%b busy=%b id=%0d pend=%b, required armed 1 and all zero",
                     got, bus.intr_pulse, bus.intr_busy, bus.intr_id, bus.intr_pending);
        end
        repeat (2) cyc();
        rst = 1'b0;
        bus.ifu_exu_vld_d = 1'b1;
        repeat (15) begin
            cyc();
            if (bus.intr_pulse !== 1'b0 || bus.intr_busy !== 1'b0 || bus.intr_id !== 0 || bus.intr_pending !== 0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_random();
        logic [IDW-1:0] exp_id;
        for (int c = 0; c < 800; c++) begin
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(0, 5) == 0) bus.intr_src[j] = ~bus.intr_src[j];
            end
            if ($urandom_range(0, 19) == 0) bus.intr_en = N'($urandom);
            bus.ifu_exu_vld_d = 1'($urandom_range(0, 1));
            bus.exu_intr_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            cyc();
            exp_id = m_id[IDW-1:0];
            checks++;
            if (bus.intr_pulse !== (m_phase == P_SEND) || bus.intr_busy !== (m_phase == P_BUSY) ||
                bus.intr_id !== exp_id || bus.intr_pending !== m_pend) begin
                errors++;
                $display("FAIL random_cycle%0d: pulse=%b busy=%b id=%0d pend=%b, required pulse=%b busy=%b id=%0d pend=%b",
                         c, bus.intr_pulse, bus.intr_busy, bus.intr_id, bus.intr_pending,
                         (m_phase == P_SEND), (m_phase == P_BUSY), exp_id, m_pend);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.intr_src      = '0;
        bus.intr_en       = '0;
        bus.ifu_exu_vld_d = 1'b0;
        bus.exu_intr_done = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_rr();
        drain();
        test_mask();
        drain();
        test_busy_rerise_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
